ula_operand_stage: RTL

ULA_OPERAND_STAGE -- requirements
Module: ula_operand_stage

---
 rtl/ula_operand_stage_pkg.sv | 27 ++
 rtl/ula_operand_stage_regfile.sv | 39 +++
 rtl/ula_operand_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ula_operand_stage_pkg.sv
// Shared definitions for the ULA operand stage: widths, register count,
// the ULA opcode encoding and the forwarding-match helper.
package ula_operand_stage_pkg;

    localparam int ULA_W    = 32;
    localparam int ULA_NREG = 16;
    localparam int ULA_AW   = 4;

    typedef enum logic [1:0] {
        ULA_ADD = 2'b00,
        ULA_SUB = 2'b01,
        ULA_AND = 2'b10,
        ULA_OR  = 2'b11
    } ula_op_e;

    // A pipeline slot supplies a source operand only if it holds a valid,
    // register-writing operation whose destination matches the source.
    function automatic logic fwd_hit(
        input logic              valid,
        input logic              we,
        input logic [ULA_AW-1:0] rd,
        input logic [ULA_AW-1:0] ra
    );
        return valid && we && (rd == ra);
    endfunction

endpackage

// File: rtl/ula_operand_stage_regfile.sv
// Operand register file: two combinational read ports, one debug read
// port, one synchronous write port, asynchronous clear of every entry.
module ula_regfile
    import ula_operand_stage_pkg::*;
#(
    parameter int NREG = ULA_NREG,
    parameter int W    = ULA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ULA_AW-1:0] ra1,
    input  logic [ULA_AW-1:0] ra2,
    output logic [W-1:0]      rd1,
    output logic [W-1:0]      rd2,
    input  logic              we,
    input  logic [ULA_AW-1:0] wa,
    input  logic [W-1:0]      wd,
    input  logic [ULA_AW-1:0] dbg_addr,
    output logic [W-1:0]      dbg_data
);

    logic [W-1:0] regs_r [NREG];

    // Storage: cleared on reset, one entry written per enabled clock edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else if (we) begin
            regs_r[wa] <= wd;
        end
    end

    assign rd1      = regs_r[ra1];
    assign rd2      = regs_r[ra2];
    assign dbg_data = regs_r[dbg_addr];

endmodule

// File: rtl/ula_operand_stage.sv
// Two-stage operand issue / writeback around an external ULA. S1 holds the
// resolved operands presented to the ULA, S2 holds the ULA result until it
// retires into the register file. Results still in flight are forwarded to
// newly issued operations so dependent operations never stall.
module ula_operand_stage
    import ula_operand_stage_pkg::*;
#(
    parameter int NREG = ULA_NREG,
    parameter int W    = ULA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [ULA_AW-1:0] in_ra1,
    input  logic [ULA_AW-1:0] in_ra2,
    input  logic [ULA_AW-1:0] in_rd,
    input  logic              in_we,
    input  logic              hold,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [1:0]        alu_control,
    input  logic [W-1:0]      alu_y,
    output logic              wb_valid,
    output logic [ULA_AW-1:0] wb_rd,
    output logic [W-1:0]      wb_data,
    input  logic [ULA_AW-1:0] dbg_addr,
    output logic [W-1:0]      dbg_data
);

    // Issue stage (S1)
    logic              s1_valid_r;
    logic [W-1:0]      s1_a_r;
    logic [W-1:0]      s1_b_r;
    ula_op_e           s1_op_r;
    logic [ULA_AW-1:0] s1_rd_r;
    logic              s1_we_r;

    // Writeback stage (S2)
    logic              s2_valid_r;
    logic [W-1:0]      s2_y_r;
    logic [ULA_AW-1:0] s2_rd_r;
    logic              s2_we_r;

    logic              accept_s;
    logic              rf_we_s;
    logic [W-1:0]      rf_rd1_s;
    logic [W-1:0]      rf_rd2_s;
    logic [W-1:0]      opa_s;
    logic [W-1:0]      opb_s;

    // Ready is gated by reset so nothing is taken while the stage is cleared.
    assign in_ready = reset_n & ~hold;
    assign accept_s = in_valid & in_ready;

    // The register file only retires S2 when the pipeline actually advances.
    assign rf_we_s  = s2_valid_r & s2_we_r & ~hold;

    ula_regfile #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .clk      (clk),
        .reset_n  (reset_n),
        .ra1      (in_ra1),
        .ra2      (in_ra2),
        .rd1      (rf_rd1_s),
        .rd2      (rf_rd2_s),
        .we       (rf_we_s),
        .wa       (s2_rd_r),
        .wd       (s2_y_r),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // Resolve operand A: youngest in-flight result wins over older ones.
    always_comb begin
        opa_s = rf_rd1_s;
        if (fwd_hit(s1_valid_r, s1_we_r, s1_rd_r, in_ra1)) begin
            opa_s = alu_y;
        end else if (fwd_hit(s2_valid_r, s2_we_r, s2_rd_r, in_ra1)) begin
            opa_s = s2_y_r;
        end else begin
            opa_s = rf_rd1_s;
        end
    end

    // Resolve operand B with the same priority as operand A.
    always_comb begin
        opb_s = rf_rd2_s;
        if (fwd_hit(s1_valid_r, s1_we_r, s1_rd_r, in_ra2)) begin
            opb_s = alu_y;
        end else if (fwd_hit(s2_valid_r, s2_we_r, s2_rd_r, in_ra2)) begin
            opb_s = s2_y_r;
        end else begin
            opb_s = rf_rd2_s;
        end
    end

    // S1: load an accepted operation, otherwise insert an all-zero bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_op_r    <= ULA_ADD;
            s1_rd_r    <= '0;
            s1_we_r    <= 1'b0;
        end else if (!hold) begin
            if (accept_s) begin
                s1_valid_r <= 1'b1;
                s1_a_r     <= opa_s;
                s1_b_r     <= opb_s;
                s1_op_r    <= ula_op_e'(in_op);
                s1_rd_r    <= in_rd;
                s1_we_r    <= in_we;
            end else begin
                s1_valid_r <= 1'b0;
                s1_a_r     <= '0;
                s1_b_r     <= '0;
                s1_op_r    <= ULA_ADD;
                s1_rd_r    <= '0;
                s1_we_r    <= 1'b0;
            end
        end
    end

    // S2: capture the ULA result together with the S1 control fields.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid_r <= 1'b0;
            s2_y_r     <= '0;
            s2_rd_r    <= '0;
            s2_we_r    <= 1'b0;
        end else if (!hold) begin
            s2_valid_r <= s1_valid_r;
            s2_y_r     <= alu_y;
            s2_rd_r    <= s1_rd_r;
            s2_we_r    <= s1_we_r;
        end
    end

    assign alu_a       = s1_a_r;
    assign alu_b       = s1_b_r;
    assign alu_control = s1_op_r;
    assign wb_valid    = s2_valid_r;
    assign wb_rd       = s2_rd_r;
    assign wb_data     = s2_y_r;

endmodule
